hash_round_sequencer: RTL and testbench

HASH_ROUND_SEQUENCER -- requirements
Module: hash_round_sequencer

---
 rtl/hash_round_sequencer.sv | 85 ++++++++
 tb/tb_hash_round_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hash_round_sequencer.sv
// SHA-256 round sequencer: steps one 512-bit block through init, 64 rounds and
// hash accumulation, and drives the datapath strobes from a registered state.
module hash_round_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       clear,
   output logic [5:0] round_idx,
   output logic       w_sel,
   output logic       sched_load,
   output logic       sched_shift,
   output logic       work_init,
   output logic       work_update,
   output logic       h_accum,
   output logic       h_init,
   output logic       busy,
   output logic       local_hash_done
);

   typedef enum logic [2:0] {
      IV_LOAD = 3'd0,
      IDLE    = 3'd1,
      INIT    = 3'd2,
      ROUND   = 3'd3,
      ACCUM   = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t     state, state_nxt;
   logic [5:0] round_nxt;
   logic       accept;

   // A new block is only taken while parked; clear (and rst) discard it.
   assign accept = load && !clear && !rst && (state == IDLE || state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IV_LOAD;
         round_idx <= '0;
      end else begin
         state     <= state_nxt;
         round_idx <= round_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      round_nxt = round_idx;
      case (state)
         IV_LOAD: begin
            state_nxt = IDLE;
            round_nxt = '0;
         end
         IDLE, DONE: begin
            if (load) state_nxt = INIT;
         end
         INIT: begin
            state_nxt = ROUND;
            round_nxt = '0;
         end
         ROUND: begin
            // 6-bit counter wraps 63 -> 0 on the way into ACCUM
            round_nxt = round_idx + 6'd1;
            if (round_idx == 6'd63) state_nxt = ACCUM;
         end
         ACCUM:   state_nxt = DONE;
         default: state_nxt = IV_LOAD;
      endcase
      if (clear) begin
         state_nxt = IV_LOAD;
         round_nxt = '0;
      end
   end

   assign sched_load      = accept;
   assign h_init          = (state == IV_LOAD);
   assign work_init       = (state == INIT);
   assign work_update     = (state == ROUND);
   assign sched_shift     = (state == ROUND);
   assign h_accum         = (state == ACCUM);
   assign busy            = (state == INIT) || (state == ROUND) || (state == ACCUM);
   assign local_hash_done = (state == DONE);
   assign w_sel           = (state == ROUND) && (round_idx >= 6'd16);

endmodule

// File: tb/tb_hash_round_sequencer.sv
// Directed bench for hash_round_sequencer: a block-age model checked every
// cycle, plus literal expectations for the latency and abort scenarios.
module tb_hash_round_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic       clear = 1'b0;
   logic [5:0] round_idx;
   logic       w_sel, sched_load, sched_shift, work_init, work_update;
   logic       h_accum, h_init, busy, local_hash_done;

   int n_chk = 0;
   int n_fail = 0;
   int acc_cnt = 0;
   int acc_base;

   // Model: age = cycles since the block was accepted (-1 when none).
   // age 0 = init, 1..64 = rounds 0..63, 65 = accumulate.
   int age = -1;
   bit iv = 1'b0;
   bit done_m = 1'b0;
   bit mvalid = 1'b0;

   always #5 clk = ~clk;

   hash_round_sequencer dut (
      .clk(clk), .rst(rst), .load(load), .clear(clear),
      .round_idx(round_idx), .w_sel(w_sel), .sched_load(sched_load),
      .sched_shift(sched_shift), .work_init(work_init), .work_update(work_update),
      .h_accum(h_accum), .h_init(h_init), .busy(busy),
      .local_hash_done(local_hash_done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      mvalid <= 1'b1;
      if (rst || clear) begin
         iv <= 1'b1; age <= -1; done_m <= 1'b0;
      end else if (iv) begin
         iv <= 1'b0;
      end else if (age < 0) begin
         if (load) begin age <= 0; done_m <= 1'b0; end
      end else if (age == 65) begin
         age <= -1; done_m <= 1'b1;
      end else begin
         age <= age + 1;
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("m_h_init", 32'(h_init), 32'(iv));
         chk("m_work_init", 32'(work_init), 32'(age == 0));
         chk("m_work_update", 32'(work_update), 32'(age >= 1 && age <= 64));
         chk("m_sched_shift", 32'(sched_shift), 32'(age >= 1 && age <= 64));
         chk("m_round_idx", 32'(round_idx), (age >= 1 && age <= 64) ? 32'(age - 1) : 32'd0);
         chk("m_w_sel", 32'(w_sel), 32'(age >= 17 && age <= 64));
         chk("m_h_accum", 32'(h_accum), 32'(age == 65));
         chk("m_busy", 32'(busy), 32'(age >= 0));
         chk("m_done", 32'(local_hash_done), 32'(done_m));
         chk("m_sched_load", 32'(sched_load), 32'(load && !clear && !rst && !iv && age < 0));
         if (h_accum === 1'b1) acc_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset
      repeat (3) nxt();
      #1;
      chk("rst_h_init", 32'(h_init), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_round", 32'(round_idx), 32'd0);
      chk("rst_done", 32'(local_hash_done), 32'd0);
      nxt(); rst = 1'b0; #1;
      chk("rel_h_init", 32'(h_init), 32'd1);
      nxt(); #1;
      chk("idle_h_init", 32'(h_init), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // single block, fixed latency
      nxt(); load = 1'b1; #1;
      chk("a_sched_load", 32'(sched_load), 32'd1);
      nxt(); load = 1'b0; #1;
      chk("a_work_init", 32'(work_init), 32'd1);
      chk("a_busy", 32'(busy), 32'd1);
      for (int r = 0; r < 64; r++) begin
         nxt(); #1;
         chk("a_work_update", 32'(work_update), 32'd1);
         chk("a_round", 32'(round_idx), 32'(r));
         chk("a_w_sel", 32'(w_sel), 32'(r >= 16));
      end
      nxt(); #1;
      chk("a_h_accum", 32'(h_accum), 32'd1);
      chk("a_accum_round", 32'(round_idx), 32'd0);
      for (int i = 0; i < 20; i++) begin
         nxt(); #1;
         chk("a_done_hold", 32'(local_hash_done), 32'd1);
         chk("a_done_busy", 32'(busy), 32'd0);
      end
      chk("a_acc_cnt", 32'(acc_cnt), 32'd1);

      // back-to-back: second load in the first DONE cycle
      acc_base = acc_cnt;
      nxt(); load = 1'b1; nxt(); load = 1'b0;
      repeat (66) nxt();
      load = 1'b1; #1;
      chk("b_first_done", 32'(local_hash_done), 32'd1);
      chk("b_sched_load", 32'(sched_load), 32'd1);
      nxt(); load = 1'b0; #1;
      chk("b_done_drop", 32'(local_hash_done), 32'd0);
      chk("b_work_init", 32'(work_init), 32'd1);
      repeat (65) nxt();
      #1;
      chk("b_h_accum", 32'(h_accum), 32'd1);
      nxt(); #1;
      chk("b_done", 32'(local_hash_done), 32'd1);
      chk("b_acc_twice", 32'(acc_cnt - acc_base), 32'd2);

      // loads during a block are ignored
      nxt(); load = 1'b1; nxt(); #1;
      chk("c_init_sched_load", 32'(sched_load), 32'd0);
      chk("c_init", 32'(work_init), 32'd1);
      nxt(); load = 1'b0;
      repeat (30) nxt();
      load = 1'b1; #1;
      chk("c_round30", 32'(round_idx), 32'd30);
      chk("c_sched_load", 32'(sched_load), 32'd0);
      for (int r = 31; r < 64; r++) begin
         nxt(); load = 1'b0; #1;
         chk("c_round", 32'(round_idx), 32'(r));
      end
      nxt(); #1;
      chk("c_h_accum", 32'(h_accum), 32'd1);
      nxt(); #1;
      chk("c_done", 32'(local_hash_done), 32'd1);

      // clear at round 40
      acc_base = acc_cnt;
      nxt(); load = 1'b1; nxt(); load = 1'b0;
      repeat (41) nxt();
      clear = 1'b1; #1;
      chk("d_round40", 32'(round_idx), 32'd40);
      nxt(); clear = 1'b0; #1;
      chk("d_h_init", 32'(h_init), 32'd1);
      chk("d_busy_iv", 32'(busy), 32'd0);
      nxt(); #1;
      chk("d_idle_h_init", 32'(h_init), 32'd0);
      chk("d_busy", 32'(busy), 32'd0);
      repeat (30) nxt();
      #1;
      chk("d_no_accum", 32'(acc_cnt - acc_base), 32'd0);
      chk("d_no_done", 32'(local_hash_done), 32'd0);

      // load and clear together in DONE
      nxt(); load = 1'b1; nxt(); load = 1'b0;
      repeat (66) nxt();
      load = 1'b1; clear = 1'b1; #1;
      chk("e_done", 32'(local_hash_done), 32'd1);
      chk("e_sched_load", 32'(sched_load), 32'd0);
      nxt(); load = 1'b0; clear = 1'b0; #1;
      chk("e_h_init", 32'(h_init), 32'd1);
      chk("e_work_init", 32'(work_init), 32'd0);
      chk("e_done_fall", 32'(local_hash_done), 32'd0);
      nxt(); #1;
      chk("e_idle", 32'(h_init | busy | work_init), 32'd0);

      // reset in the middle of a block
      acc_base = acc_cnt;
      nxt(); load = 1'b1; nxt(); load = 1'b0;
      repeat (11) nxt();
      rst = 1'b1; #1;
      chk("f_round10", 32'(round_idx), 32'd10);
      nxt(); rst = 1'b0; #1;
      chk("f_round", 32'(round_idx), 32'd0);
      chk("f_busy", 32'(busy), 32'd0);
      chk("f_h_init", 32'(h_init), 32'd1);
      chk("f_work_update", 32'(work_update), 32'd0);
      nxt(); #1;
      chk("f_idle_h_init", 32'(h_init), 32'd0);
      chk("f_idle_busy", 32'(busy), 32'd0);
      repeat (70) nxt();
      #1;
      chk("f_no_accum", 32'(acc_cnt - acc_base), 32'd0);
      chk("f_no_done", 32'(local_hash_done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
